// File: rtl/bram_result_reader_if.sv
// BRAM1 read port and result stream grouped as one bundle.
// master is the reader's view; slave is the memory/sink view.
interface bram_result_reader_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8
);
    logic [AWIDTH-1:0] addr_b1_o;
    logic              ce_b1_o;
    logic              we_b1_o;
    logic [DWIDTH-1:0] d_b1_o;
    logic [DWIDTH-1:0] q_b1_i;

    logic              m_valid_o;
    logic              m_ready_i;
    logic [DWIDTH-1:0] m_data_o;
    logic              m_last_o;

    modport master (
        output addr_b1_o,
        output ce_b1_o,
        output we_b1_o,
        output d_b1_o,
        input  q_b1_i,
        output m_valid_o,
        input  m_ready_i,
        output m_data_o,
        output m_last_o
    );

    modport slave (
        input  addr_b1_o,
        input  ce_b1_o,
        input  we_b1_o,
        input  d_b1_o,
        output q_b1_i,
        input  m_valid_o,
        output m_ready_i,
        input  m_data_o,
        input  m_last_o
    );
endinterface

// File: rtl/bram_result_reader.sv
// Drains drain_count_i rows from BRAM1 (address 0 upward) onto a valid/ready stream.
// Optional stall counter port enabled by defining BRAM_READER_STALL_CNT_EN.
module bram_result_reader #(
    parameter int unsigned CNT_BIT  = 31,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 8,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_drain_i,
    input  logic [CNT_BIT-1:0] drain_count_i,
    output logic               idle_o,
    output logic               run_o,
    output logic               done_o,
`ifdef BRAM_READER_STALL_CNT_EN
    output logic [CNT_BIT-1:0] stall_cnt_o,
`endif
    bram_result_reader_if.master bus
);

    if (MEM_SIZE > (1 << AWIDTH)) begin : g_mem_size_check
        $error("MEM_SIZE exceeds the BRAM1 address space");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CNT_BIT-1:0] count_q;
    logic [CNT_BIT-1:0] issue_cnt_q;
    logic [CNT_BIT-1:0] beat_cnt_q;
    logic               inflight_q;

    // Two-entry output buffer: one slot for the row on the wire, one for the row in flight.
    logic [DWIDTH-1:0]  buf_mem_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         buf_cnt_q;
    logic [1:0]         buf_cnt_d;

    logic               start_ok;
    logic               push;
    logic               pop;
    logic               issue;
    logic               last_beat;
    logic               buf_valid;
    logic [2:0]         occupancy;

    assign start_ok  = (state_q == StIdle) && start_drain_i;
    assign buf_valid = (buf_cnt_q != 2'd0);
    assign push      = inflight_q;
    assign pop       = buf_valid && bus.m_ready_i;
    assign last_beat = (beat_cnt_q == (count_q - {{(CNT_BIT-1){1'b0}}, 1'b1}));

    // Rows already buffered plus the one returning, minus the one leaving this cycle.
    assign occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == StRun) && (issue_cnt_q < count_q) && (occupancy < 3'd2);

    assign buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_drain_i) begin
                    state_d = (drain_count_i != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (pop && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (start_ok) begin
                count_q     <= drain_count_i;
                issue_cnt_q <= '0;
                beat_cnt_q  <= '0;
            end else begin
                if (issue) begin
                    issue_cnt_q <= issue_cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
                end
                if (pop) begin
                    beat_cnt_q <= beat_cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem_q[wr_ptr_q] <= bus.q_b1_i;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_d;
        end
    end

`ifdef BRAM_READER_STALL_CNT_EN
    logic [CNT_BIT-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (start_ok) begin
            stall_cnt_q <= '0;
        end else if ((state_q == StRun) && buf_valid && !bus.m_ready_i &&
                     (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign idle_o = (state_q == StIdle);
    assign run_o  = (state_q == StRun);
    assign done_o = (state_q == StDone);

    assign bus.ce_b1_o   = issue;
    assign bus.addr_b1_o = issue ? issue_cnt_q[AWIDTH-1:0] : '0;
    assign bus.we_b1_o   = 1'b0;
    assign bus.d_b1_o    = '0;

    assign bus.m_valid_o = buf_valid;
    assign bus.m_data_o  = buf_valid ? buf_mem_q[rd_ptr_q] : '0;
    assign bus.m_last_o  = buf_valid && last_beat;

endmodule

// File: tb/tb_bram_result_reader.sv
// Self-checking bench: table of drains plus random drains against a row-sequence model.
// Stall counter is checked when BRAM_READER_STALL_CNT_EN is defined.
module tb_bram_result_reader;

    localparam int CNT_BIT = 31;
    localparam int DWIDTH  = 32;
    localparam int AWIDTH  = 8;

    logic               clk     = 1'b0;
    logic               reset_n = 1'b1;
    logic               start   = 1'b0;
    logic [CNT_BIT-1:0] dcount  = '0;
    logic               idle;
    logic               run;
    logic               done;
`ifdef BRAM_READER_STALL_CNT_EN
    logic [CNT_BIT-1:0] stall_cnt;
`endif

    bram_result_reader_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bus ();

    bram_result_reader #(
        .CNT_BIT (CNT_BIT),
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .MEM_SIZE(256)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_drain_i(start),
        .drain_count_i(dcount),
        .idle_o       (idle),
        .run_o        (run),
        .done_o       (done),
`ifdef BRAM_READER_STALL_CNT_EN
        .stall_cnt_o  (stall_cnt),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // BRAM1 model: registered read, data valid the cycle after ce.
    logic [DWIDTH-1:0] mem [256];
    logic [DWIDTH-1:0] q_model = '0;
    always @(posedge clk) begin
        if (bus.ce_b1_o) q_model <= mem[bus.addr_b1_o];
    end
    assign bus.q_b1_i = q_model;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a drain of n rows is the row sequence mem[i mod 256], i = 0..n-1.
    int          exp_count = 0;
    int          beat_idx  = 0;
    int          n_iss     = 0;
    int          n_pop     = 0;
    int          stalls    = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", bus.m_valid_o, 1);
                chk("stall_data_held", bus.m_data_o, prev_data);
            end
            chk("outstanding_le_2", 64'((n_iss - n_pop) <= 2), 1);
            if (bus.ce_b1_o) begin
                chk("read_addr", bus.addr_b1_o, n_iss % 256);
                n_iss++;
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                if (beat_idx >= exp_count) begin
                    chk("extra_beat", beat_idx, exp_count);
                end else begin
                    chk("beat_data", bus.m_data_o, mem[beat_idx % 256]);
                    chk("beat_last", bus.m_last_o, 64'(beat_idx == exp_count - 1));
                end
                beat_idx++;
                n_pop++;
            end
            if (run && bus.m_valid_o && !bus.m_ready_i) stalls++;
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_data  = bus.m_data_o;
        end
    end

    function automatic logic rdy(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 3) == 0;
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_run"}, run, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ce"}, bus.ce_b1_o, 0);
        chk({tag, "_addr"}, bus.addr_b1_o, 0);
        chk({tag, "_valid"}, bus.m_valid_o, 0);
        chk({tag, "_data"}, bus.m_data_o, 0);
        chk({tag, "_last"}, bus.m_last_o, 0);
    endtask

    // exp_cyc: edges from the start edge to the DONE-entry edge, or -1 if unchecked.
    task automatic run_drain(input int cnt, input int mode, input bit restart, input int exp_cyc);
        int  i;
        bit  got_done;
        int  budget;
        exp_count = cnt;
        beat_idx  = 0;
        n_iss     = 0;
        n_pop     = 0;
        stalls    = 0;
        budget    = 10 * cnt + 40;
        @(posedge clk); #1;
        start = 1'b1;
        dcount = CNT_BIT'(cnt);
        bus.m_ready_i = rdy(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        dcount = CNT_BIT'($urandom_range(1, 50));
        bus.m_ready_i = rdy(mode, 1);
        got_done = 1'b0;
        i = 0;
        while (i < budget && !got_done) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else begin
                @(posedge clk); #1;
                bus.m_ready_i = rdy(mode, i + 2);
                start = restart && (i == 2);
                i++;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            chk("done_timeout", 0, 1);
        end else begin
            if (exp_cyc >= 0) chk("done_latency", i, exp_cyc);
            chk("beat_count", beat_idx, cnt);
            chk("read_count", n_iss, cnt);
`ifdef BRAM_READER_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stalls);
`endif
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("back_to_idle", idle, 1);
        end
    endtask

    typedef struct {
        int cnt;
        int mode;
        bit restart;
        int exp_cyc;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   k;
        vecs[0] = '{cnt: 4,   mode: 0, restart: 1'b0, exp_cyc: 6};
        vecs[1] = '{cnt: 4,   mode: 1, restart: 1'b0, exp_cyc: -1};
        vecs[2] = '{cnt: 0,   mode: 0, restart: 1'b0, exp_cyc: 0};
        vecs[3] = '{cnt: 1,   mode: 0, restart: 1'b0, exp_cyc: 3};
        vecs[4] = '{cnt: 258, mode: 0, restart: 1'b0, exp_cyc: 260};
        vecs[5] = '{cnt: 4,   mode: 0, restart: 1'b1, exp_cyc: 6};
        vecs[6] = '{cnt: 7,   mode: 1, restart: 1'b1, exp_cyc: -1};
        vecs[7] = '{cnt: 2,   mode: 2, restart: 1'b0, exp_cyc: -1};

        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
        mem[2] = 32'h0C0B_0A09;
        mem[3] = 32'h100F_0E0D;
        bus.m_ready_i = 1'b1;

        #1 reset_n = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_drain(vecs[v].cnt, vecs[v].mode, vecs[v].restart, vecs[v].exp_cyc);
        end

        // Reset after the second beat of a 4-row drain, then a fresh 2-row drain.
        exp_count = 4;
        beat_idx  = 0;
        n_iss     = 0;
        n_pop     = 0;
        @(posedge clk); #1;
        start = 1'b1;
        dcount = 4;
        bus.m_ready_i = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (beat_idx < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reset_seq_two_beats", beat_idx, 2);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        run_drain(2, 0, 1'b0, 4);

        for (int r = 0; r < 8; r++) begin
            run_drain($urandom_range(1, 40), 2, 1'(r % 2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_result_reader.md
Name: bram_result_reader

Overview:
- Drains accumulated results from BRAM1 after the accumulator run has finished writing them.
- Reads drain_count_i consecutive rows starting at address 0 through the BRAM1 memory interface.
- Each row has 4 packed 8-bit results (32 bits).
- Streams each row out on a valid/ready master port, with a 2-entry output buffer that absorbs the 1-cycle BRAM read latency.

Parameters:
- CNT_BIT, 31, width of drain_count_i and the internal row counters.
- DWIDTH, 32, BRAM1 data width and stream data width.
- AWIDTH, 8, BRAM1 address width.
- MEM_SIZE, 256, BRAM1 depth (documentation only; addresses wrap at 2^AWIDTH).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- start_drain_i  input  1  start pulse; sampled only in IDLE.
- drain_count_i  input  CNT_BIT  number of rows to drain; latched on start.
- idle_o  output  1  high in IDLE.
- run_o  output  1  high in RUN.
- done_o  output  1  high for exactly one cycle in DONE.
- addr_b1_o  output  AWIDTH  BRAM1 address.
- ce_b1_o  output  1  BRAM1 chip enable.
- we_b1_o  output  1  BRAM1 write enable; tied to 0 (read only).
- d_b1_o  output  DWIDTH  BRAM1 write data; tied to 0.
- q_b1_i  input  DWIDTH  BRAM1 read data, valid 1 cycle after ce_b1_o is high.
- m_valid_o  output  1  stream data valid.
- m_ready_i  input  1  stream sink ready.
- m_data_o  output  DWIDTH  stream data (row contents unmodified).
- m_last_o  output  1  high with the final row of the drain.

Behaviour:
- Reset: state=IDLE, idle_o=1, run_o=0, done_o=0, ce_b1_o=0, addr_b1_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, buffer empty, all counters 0.
- FSM:
  - IDLE -> RUN on start_drain_i=1 with drain_count_i != 0; latch the count; reset the issue and beat counters to 0.
  - IDLE -> DONE on start_drain_i=1 with drain_count_i == 0; no reads are issued and no beats are output.
  - RUN -> DONE in the cycle after the handshake (m_valid_o & m_ready_i) on the beat with m_last_o=1.
  - DONE -> IDLE unconditionally after one cycle.
- start_drain_i is ignored in RUN and DONE.
- Read issue:
  - In RUN, assert ce_b1_o=1 with addr_b1_o = issue_cnt[AWIDTH-1:0] when issue_cnt < count and (buf_cnt + inflight - pop) < 2.
  - pop = m_valid_o & m_ready_i in the same cycle.
  - issue_cnt increments on each issue.
  - inflight is a 1-bit register equal to the previous cycle's ce_b1_o.
- Return path: when inflight=1, q_b1_i is pushed into the 2-entry FIFO in that cycle.
- Output:
  - m_valid_o = buffer not empty; m_data_o = head entry; m_data_o is held stable while m_valid_o=1 and m_ready_i=0.
  - m_last_o = m_valid_o & (beat_cnt == count-1); beat_cnt increments on each pop.
- Throughput: with m_ready_i held high, one beat per cycle; the first beat appears 2 cycles after the RUN entry edge.
- Simultaneous push and pop with a full buffer is legal; occupancy is unchanged.
- The issue rule guarantees a push never overflows the buffer.
- Backpressure: m_ready_i=0 for any number of cycles stalls issue after at most 2 outstanding rows; no data is lost or duplicated.
- Addresses wrap modulo 2^AWIDTH when count > 2^AWIDTH; the counters themselves do not wrap before count.
- Reset asserted mid-drain returns everything to reset values immediately and flushes the buffer; the next start begins at address 0.

Optional Feature:
- Macro BRAM_READER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt_o [CNT_BIT-1:0].
  - In RUN, stall_cnt_o counts cycles with m_valid_o=1 and m_ready_i=0.
  - Cleared to 0 on a start accepted in IDLE and on reset; holds its value in DONE/IDLE; saturates at all-ones.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Preload BRAM1 rows 0..3 with 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; count=4; m_ready_i=1 -> 4 consecutive beats in that order; m_last_o high only on 0x100F0E0D; done_o pulses once; total 6 cycles from start to DONE.
- Same data; m_ready_i toggles 1,0,0,1,... -> identical beat sequence with no drops or duplicates; ce_b1_o never exceeds 2 outstanding rows; m_data_o stable during stalls; stall_cnt_o equals the counted stall cycles (macro defined).
- count=0 -> ce_b1_o never asserts; m_valid_o stays 0; done_o pulses 1 cycle after start; FSM returns to IDLE.
- count=258 with AWIDTH=8 -> addresses 0..255 then 0,1; 258 beats; m_last_o on the 258th beat.
- Assert reset_n=0 after the 2nd beat of a 4-row drain -> all outputs take reset values asynchronously; a new start with count=2 outputs rows 0 and 1 only.
- Pulse start_drain_i again during RUN -> ignored; the drain completes with the originally latched count.
